// File: rtl/pcap_pkg.sv
// pcap_pkg: shared constants and types for the pcap stream parser.
//   PCAP_MAGIC_LE/BE : the first four file bytes, packed in the order they
//                      are read (byte 0 in bits 31:24).
//   GHDR_LEN, RHDR_LEN, INCL_LEN_OFS : header geometry in bytes.
//   pcap_state_t     : parser FSM states.
//   incl_len_shift   : folds one incl_len byte into the partially built value.
package pcap_pkg;

  localparam logic [31:0] PCAP_MAGIC_LE = 32'hD4C3_B2A1;
  localparam logic [31:0] PCAP_MAGIC_BE = 32'hA1B2_C3D4;

  localparam int GHDR_LEN     = 24;
  localparam int RHDR_LEN     = 16;
  localparam int INCL_LEN_OFS = 8;

  typedef enum logic [2:0] {
    GHDR,
    RHDR,
    DATA,
    SKIP,
    ERR
  } pcap_state_t;

  // Little-endian files deliver the least significant byte first, so each new
  // byte enters at the top and slides down; big-endian files shift in at the
  // bottom. After four calls the value is complete either way.
  function automatic logic [31:0] incl_len_shift(input logic [31:0] cur,
                                                 input logic [7:0]  b,
                                                 input logic        big_endian);
    return big_endian ? {cur[23:0], b} : {b, cur[31:8]};
  endfunction

endpackage

// File: rtl/pcap_beat_packer.sv
// pcap_beat_packer: collects accepted payload bytes into a DATA_W-bit beat
// and presents closed beats on an output register.
//   clk, rst          : clock, synchronous active-low reset.
//   in_valid_i        : a payload byte is being accepted this cycle (the
//                       caller only asserts it while in_ready_o is high).
//   in_data_i         : the payload byte.
//   in_last_i         : the byte is the last of its record.
//   in_ready_o        : the packer can take a byte this cycle.
//   m_axis_tdata/tkeep/tlast/tvalid/tready : output beat stream.
//
// Handshake: a beat transfers on a rising edge where tvalid && tready. Once
// tvalid is high the beat holds stable until it transfers. A byte can be taken
// whenever the output register is empty or draining this cycle, so a byte that
// closes a beat always has a free slot to land in.
module pcap_beat_packer #(
  parameter int DATA_W = 512
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid_i,
  input  logic [7:0]          in_data_i,
  input  logic                in_last_i,
  output logic                in_ready_o,
  output logic [DATA_W-1:0]   m_axis_tdata,
  output logic [DATA_W/8-1:0] m_axis_tkeep,
  output logic                m_axis_tlast,
  output logic                m_axis_tvalid,
  input  logic                m_axis_tready
);

  localparam int LANES = DATA_W / 8;
  localparam int LW    = $clog2(LANES);

  logic [DATA_W-1:0] acc_data_q;
  logic [LANES-1:0]  acc_keep_q;
  logic [LW-1:0]     lane_q;

  logic [DATA_W-1:0] out_data_q;
  logic [LANES-1:0]  out_keep_q;
  logic              out_last_q;
  logic              out_valid_q;

  logic [DATA_W-1:0] beat_data;
  logic [LANES-1:0]  beat_keep;
  logic              beat_close;

  // The accumulator with the incoming byte merged into its lane; this is what
  // either stays in the accumulator or moves to the output register.
  always_comb begin
    beat_data = acc_data_q;
    beat_keep = acc_keep_q;
    beat_data[{lane_q, 3'b000} +: 8] = in_data_i;
    beat_keep[lane_q]                = 1'b1;
    beat_close = (lane_q == LW'(LANES - 1)) || in_last_i;
  end

  assign in_ready_o = !out_valid_q || m_axis_tready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      acc_data_q  <= '0;
      acc_keep_q  <= '0;
      lane_q      <= '0;
      out_data_q  <= '0;
      out_keep_q  <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      if (out_valid_q && m_axis_tready) begin
        out_valid_q <= 1'b0;
      end
      if (in_valid_i) begin
        if (beat_close) begin
          out_data_q  <= beat_data;
          out_keep_q  <= beat_keep;
          out_last_q  <= in_last_i;
          out_valid_q <= 1'b1;
          // Clearing the accumulator keeps unused lanes of the next beat zero.
          acc_data_q  <= '0;
          acc_keep_q  <= '0;
          lane_q      <= '0;
        end else begin
          acc_data_q <= beat_data;
          acc_keep_q <= beat_keep;
          lane_q     <= lane_q + LW'(1);
        end
      end
    end
  end

  assign m_axis_tdata  = out_data_q;
  assign m_axis_tkeep  = out_keep_q;
  assign m_axis_tlast  = out_last_q;
  assign m_axis_tvalid = out_valid_q;

endmodule

// File: rtl/pcap_stream_parser.sv
// pcap_stream_parser: parses a libpcap byte stream into one AXI-Stream packet
// per record.
//   clk, rst           : clock, synchronous active-low reset (0 = reset).
//   s_axis_tdata/tvalid/tready : input file bytes in file order.
//   m_axis_tdata/tkeep/tlast/tvalid/tready : output packets, byte i in lane i%64.
//   pkt_count          : records forwarded since reset (wraps).
//   err_magic          : sticky, the global header magic was not recognised.
//   err_len            : sticky, some record exceeded MAX_PKT_LEN and was skipped.
//
// Handshake: on both streams a transfer happens on a rising edge where
// tvalid && tready. Input is accepted only when the output beat register is
// empty or draining, except in ERR where everything is swallowed.
module pcap_stream_parser
  import pcap_pkg::*;
#(
  parameter int TDATA_WIDTH = 512,
  parameter int MAX_PKT_LEN = 9600
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               s_axis_tdata,
  input  logic                     s_axis_tvalid,
  output logic                     s_axis_tready,
  output logic [TDATA_WIDTH-1:0]   m_axis_tdata,
  output logic [TDATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic                     m_axis_tlast,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic [31:0]              pkt_count,
  output logic                     err_magic,
  output logic                     err_len
);

  pcap_state_t state_q;
  logic [31:0] byte_cnt_q;
  logic [31:0] incl_len_q;
  logic [31:0] magic_q;
  logic        big_endian_q;
  logic [31:0] pkt_count_q;
  logic        err_magic_q;
  logic        err_len_q;

  logic pk_ready;
  logic accept;
  logic rec_last_byte;
  logic in_ihdr_len;

  // Gated by rst so the port reads 0 during reset even before the first edge.
  assign s_axis_tready = rst && ((state_q == ERR) || pk_ready);
  assign accept        = s_axis_tvalid && s_axis_tready;
  assign rec_last_byte = (byte_cnt_q == incl_len_q - 32'd1);
  assign in_ihdr_len   = (byte_cnt_q >= 32'(INCL_LEN_OFS)) &&
                         (byte_cnt_q <  32'(INCL_LEN_OFS + 4));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= GHDR;
      byte_cnt_q   <= '0;
      incl_len_q   <= '0;
      magic_q      <= '0;
      big_endian_q <= 1'b0;
      pkt_count_q  <= '0;
      err_magic_q  <= 1'b0;
      err_len_q    <= 1'b0;
    end else if (accept) begin
      case (state_q)
        GHDR: begin
          if (byte_cnt_q < 32'd4) begin
            magic_q <= {magic_q[23:0], s_axis_tdata};
          end
          if (byte_cnt_q == 32'(GHDR_LEN - 1)) begin
            byte_cnt_q <= '0;
            if (magic_q == PCAP_MAGIC_LE) begin
              big_endian_q <= 1'b0;
              state_q      <= RHDR;
            end else if (magic_q == PCAP_MAGIC_BE) begin
              big_endian_q <= 1'b1;
              state_q      <= RHDR;
            end else begin
              err_magic_q <= 1'b1;
              state_q     <= ERR;
            end
          end else begin
            byte_cnt_q <= byte_cnt_q + 32'd1;
          end
        end

        RHDR: begin
          if (in_ihdr_len) begin
            incl_len_q <= incl_len_shift(incl_len_q, s_axis_tdata, big_endian_q);
          end
          if (byte_cnt_q == 32'(RHDR_LEN - 1)) begin
            byte_cnt_q <= '0;
            // Zero-length records produce nothing and the next header follows.
            if (incl_len_q == 32'd0) begin
              state_q <= RHDR;
            end else if (incl_len_q > 32'(MAX_PKT_LEN)) begin
              err_len_q <= 1'b1;
              state_q   <= SKIP;
            end else begin
              state_q <= DATA;
            end
          end else begin
            byte_cnt_q <= byte_cnt_q + 32'd1;
          end
        end

        DATA, SKIP: begin
          if (rec_last_byte) begin
            byte_cnt_q <= '0;
            state_q    <= RHDR;
            if (state_q == DATA) begin
              pkt_count_q <= pkt_count_q + 32'd1;
            end
          end else begin
            byte_cnt_q <= byte_cnt_q + 32'd1;
          end
        end

        ERR: begin
          state_q <= ERR;
        end

        default: begin
          state_q <= GHDR;
        end
      endcase
    end
  end

  pcap_beat_packer #(
    .DATA_W (TDATA_WIDTH)
  ) u_packer (
    .clk           (clk),
    .rst           (rst),
    .in_valid_i    (accept && (state_q == DATA)),
    .in_data_i     (s_axis_tdata),
    .in_last_i     (rec_last_byte),
    .in_ready_o    (pk_ready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready)
  );

  assign pkt_count = pkt_count_q;
  assign err_magic = err_magic_q;
  assign err_len   = err_len_q;

endmodule

// File: tb/tb_pcap_stream_parser.sv
module tb_pcap_stream_parser;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [7:0]   s_tdata = '0;
  logic         s_tvalid = 1'b0;
  logic         s_tready;
  logic [511:0] m_tdata;
  logic [63:0]  m_tkeep;
  logic         m_tlast;
  logic         m_tvalid;
  logic         m_tready = 1'b0;
  logic [31:0]  pkt_count;
  logic         err_magic;
  logic         err_len;

  always #5 clk = ~clk;

  pcap_stream_parser #(
    .TDATA_WIDTH (512),
    .MAX_PKT_LEN (9600)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tdata  (s_tdata),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tkeep  (m_tkeep),
    .m_axis_tlast  (m_tlast),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .pkt_count     (pkt_count),
    .err_magic     (err_magic),
    .err_len       (err_len)
  );

  // ---------------- scoreboard state ----------------
  int           total = 0;
  int           bad   = 0;
  logic [7:0]   stream_q[$];
  logic [576:0] exp_q[$];          // {last, keep, data}
  int           exp_pkts;
  logic         exp_err_magic;
  logic         exp_err_len;
  logic [576:0] last_beat;
  logic [576:0] held_beat;
  bit           held = 1'b0;
  bit           cmp_en = 1'b1;
  bit           ready_always = 1'b0;
  int           in_rate = 100;
  int           rdy_mode = 0;      // 0 always ready, 1 random, 2 one stall burst
  int           rdy_rate = 100;
  int           stall_left = 0;
  int           idx;

  task automatic chk(input string tag, input logic [576:0] got, input logic [576:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- stimulus builders ----------------
  task automatic put_ghdr(input logic [31:0] magic);
    for (int i = 3; i >= 0; i--) stream_q.push_back(magic[8*i +: 8]);
    for (int i = 0; i < 20; i++) stream_q.push_back(8'($urandom));
  endtask

  task automatic put_rec(input int len, input bit be, input bit ramp);
    logic [31:0] l;
    logic [7:0]  b;
    l = 32'(len);
    for (int i = 0; i < 16; i++) begin
      b = 8'($urandom);
      if (i >= 8 && i < 12) b = be ? l[8*(11-i) +: 8] : l[8*(i-8) +: 8];
      stream_q.push_back(b);
    end
    for (int i = 0; i < len; i++) stream_q.push_back(ramp ? 8'(i) : 8'($urandom));
  endtask

  // ---------------- reference model ----------------
  // Walks the file as a pcap reader would and lists the beats it should yield.
  task automatic build_model();
    logic [31:0]  magic;
    logic [31:0]  incl;
    logic [511:0] d;
    logic [63:0]  k;
    bit           le, be;
    int           pos, n, sz;
    exp_q.delete();
    exp_pkts = 0;
    exp_err_magic = 1'b0;
    exp_err_len = 1'b0;
    sz = stream_q.size();
    magic = {stream_q[0], stream_q[1], stream_q[2], stream_q[3]};
    le = (magic == 32'hD4C3B2A1);
    be = (magic == 32'hA1B2C3D4);
    if (!le && !be) begin
      exp_err_magic = 1'b1;
      return;
    end
    pos = 24;
    while (pos + 16 <= sz) begin
      if (le) incl = {stream_q[pos+11], stream_q[pos+10], stream_q[pos+9], stream_q[pos+8]};
      else    incl = {stream_q[pos+8], stream_q[pos+9], stream_q[pos+10], stream_q[pos+11]};
      pos += 16;
      if (incl == 0) continue;
      if (incl > 32'd9600) begin
        exp_err_len = 1'b1;
        pos += int'(incl);
        continue;
      end
      if (pos + int'(incl) > sz) break;
      for (int off = 0; off < int'(incl); off += 64) begin
        d = '0;
        k = '0;
        n = (int'(incl) - off < 64) ? int'(incl) - off : 64;
        for (int j = 0; j < n; j++) begin
          d[8*j +: 8] = stream_q[pos + off + j];
          k[j] = 1'b1;
        end
        exp_q.push_back({(off + 64 >= int'(incl)), k, d});
      end
      exp_pkts++;
      pos += int'(incl);
    end
  endtask

  // ---------------- driver / monitor ----------------
  task automatic apply_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    s_tvalid = 1'b0;
    m_tready = 1'b0;
    held = 1'b0;
    @(negedge clk);
    chk("rst_sready_now", 577'(s_tready), 577'(0));
    @(negedge clk);
    chk("rst_tdata", 577'(m_tdata), 577'(0));
    chk("rst_ctrl", 577'({s_tready, m_tvalid, m_tlast, m_tkeep, pkt_count, err_magic, err_len}), 577'(0));
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic run_stream(input int max_cycles, input bit must_finish);
    logic [576:0] cur;
    logic [576:0] e;
    bit done;
    idx = 0;
    done = 1'b0;
    for (int cyc = 0; cyc < max_cycles && !done; cyc++) begin
      @(posedge clk); #1;
      s_tvalid = (idx < stream_q.size()) && ($urandom_range(0, 99) < in_rate);
      s_tdata  = s_tvalid ? stream_q[idx] : 8'($urandom);
      case (rdy_mode)
        1: m_tready = ($urandom_range(0, 99) < rdy_rate);
        2: begin
          if (stall_left > 0 && m_tvalid) begin
            m_tready = 1'b0;
            stall_left--;
          end else m_tready = 1'b1;
        end
        default: m_tready = 1'b1;
      endcase
      @(negedge clk);
      cur = {m_tlast, m_tkeep, m_tdata};
      if (held) begin
        chk("hold_valid", 577'(m_tvalid), 577'(1));
        chk("hold_stable", cur, held_beat);
      end
      held = 1'b0;
      if (m_tvalid) begin
        if (!m_tready) begin
          chk("stall_sready", 577'(s_tready), 577'(0));
          held = 1'b1;
          held_beat = cur;
        end else begin
          last_beat = cur;
          if (cmp_en) begin
            if (exp_q.size() == 0) chk("extra_beat", cur, 577'(0));
            else begin
              e = exp_q.pop_front();
              chk("beat", cur, e);
            end
          end
        end
      end
      if (ready_always) chk("err_sready", 577'(s_tready), 577'(1));
      if (s_tvalid && s_tready) idx++;
      done = (idx == stream_q.size()) && (!cmp_en || exp_q.size() == 0) && !m_tvalid;
    end
    if (must_finish && !done) chk("timeout", 577'(0), 577'(1));
    @(posedge clk); #1;
    s_tvalid = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic end_checks(input string tag);
    chk({tag, "_pkts"}, 577'(pkt_count), 577'(exp_pkts));
    chk({tag, "_errm"}, 577'(err_magic), 577'(exp_err_magic));
    chk({tag, "_errl"}, 577'(err_len), 577'(exp_err_len));
    chk({tag, "_left"}, 577'(exp_q.size()), 577'(0));
  endtask

  task automatic new_test(input int irate, input int rmode, input int rrate);
    apply_reset();
    stream_q.delete();
    in_rate = irate;
    rdy_mode = rmode;
    rdy_rate = rrate;
    cmp_en = 1'b1;
    ready_always = 1'b0;
  endtask

  // ---------------- tests ----------------
  initial begin
    bit be;
    int nrec;
    int len;

    // LE, one 60-byte ramp record.
    new_test(100, 0, 100);
    put_ghdr(32'hD4C3B2A1);
    put_rec(60, 1'b0, 1'b1);
    build_model();
    run_stream(400, 1'b1);
    end_checks("t1");
    chk("t1_keep", 577'(last_beat[575:512]), 577'(64'h0FFF_FFFF_FFFF_FFFF));
    chk("t1_lane59", 577'(last_beat[8*59 +: 8]), 577'(8'h3B));
    chk("t1_lanes_hi", 577'(last_beat[511:480]), 577'(0));
    chk("t1_last", 577'(last_beat[576]), 577'(1));
    chk("t1_count", 577'(pkt_count), 577'(1));

    // LE, 128 then 1 byte.
    new_test(100, 0, 100);
    put_ghdr(32'hD4C3B2A1);
    put_rec(128, 1'b0, 1'b0);
    put_rec(1, 1'b0, 1'b0);
    build_model();
    chk("t2_nbeats", 577'(exp_q.size()), 577'(3));
    run_stream(600, 1'b1);
    end_checks("t2");
    chk("t2_lastkeep", 577'(last_beat[576:512]), 577'({1'b1, 64'h1}));

    // BE, 65-byte record.
    new_test(100, 0, 100);
    put_ghdr(32'hA1B2C3D4);
    put_rec(65, 1'b1, 1'b0);
    build_model();
    run_stream(500, 1'b1);
    end_checks("t3");
    chk("t3_lastkeep", 577'(last_beat[576:512]), 577'({1'b1, 64'h1}));
    chk("t3_count", 577'(pkt_count), 577'(1));

    // Bad magic, then 200 more bytes that must all be swallowed.
    new_test(100, 0, 100);
    put_ghdr(32'h12345678);
    for (int i = 0; i < 200; i++) stream_q.push_back(8'($urandom));
    build_model();
    ready_always = 1'b1;
    run_stream(600, 1'b1);
    ready_always = 1'b0;
    end_checks("t4");
    chk("t4_errm", 577'(err_magic), 577'(1));

    // Oversize record skipped, then a 64-byte record forwarded.
    new_test(100, 0, 100);
    put_ghdr(32'hD4C3B2A1);
    put_rec(10000, 1'b0, 1'b0);
    put_rec(64, 1'b0, 1'b0);
    build_model();
    run_stream(11000, 1'b1);
    end_checks("t5");
    chk("t5_errl", 577'(err_len), 577'(1));
    chk("t5_beat", 577'(last_beat[576:512]), 577'({1'b1, {64{1'b1}}}));

    // Length boundary: exactly MAX forwarded, MAX+1 skipped, a zero-length record ignored.
    new_test(100, 0, 100);
    put_ghdr(32'hA1B2C3D4);
    put_rec(9600, 1'b1, 1'b0);
    put_rec(0, 1'b1, 1'b0);
    put_rec(9601, 1'b1, 1'b0);
    put_rec(5, 1'b1, 1'b0);
    build_model();
    run_stream(20000, 1'b1);
    end_checks("t6");
    chk("t6_count", 577'(pkt_count), 577'(2));

    // Five-cycle stall on the first beat of a long record.
    new_test(100, 2, 100);
    stall_left = 5;
    put_ghdr(32'hD4C3B2A1);
    put_rec(200, 1'b0, 1'b0);
    build_model();
    run_stream(600, 1'b1);
    end_checks("t7");

    // Randomised files with random gaps and backpressure.
    for (int t = 0; t < 6; t++) begin
      new_test(60 + $urandom_range(0, 40), 1, 50 + $urandom_range(0, 50));
      be = $urandom_range(0, 1);
      put_ghdr(be ? 32'hA1B2C3D4 : 32'hD4C3B2A1);
      nrec = $urandom_range(3, 5);
      for (int r = 0; r < nrec; r++) begin
        case ($urandom_range(0, 5))
          0: len = 0;
          1: len = 64;
          2: len = 1;
          default: len = $urandom_range(2, 300);
        endcase
        put_rec(len, be, 1'b0);
      end
      build_model();
      run_stream(8000, 1'b1);
      end_checks("rnd");
    end

    // Reset in the middle of a record, then replay the same file cleanly.
    new_test(100, 0, 100);
    put_ghdr(32'hD4C3B2A1);
    put_rec(200, 1'b0, 1'b0);
    cmp_en = 1'b0;
    run_stream(110, 1'b0);
    apply_reset();
    cmp_en = 1'b1;
    build_model();
    run_stream(600, 1'b1);
    end_checks("t8");
    chk("t8_count", 577'(pkt_count), 577'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
